// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM
// states and fixed constants.
package muldiv_pkg;

    localparam int          ITER_COUNT = 32;
    localparam logic [31:0] DIV0_LO    = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        FIX  = 2'd3
    } state_t;

    // Signed variants need magnitude conversion before and after the core loop.
    function automatic logic op_is_signed(input op_t o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling around the unsigned iterative core.
// Pre-side: operand magnitudes and result/remainder sign flags.
// Post-side: re-applies signs to the raw core result and handles b == 0.
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              is_signed,
    input  logic              is_div,
    input  logic [XLEN-1:0]   in_a,
    input  logic [XLEN-1:0]   in_b,
    output logic [XLEN-1:0]   mag_a,
    output logic [XLEN-1:0]   mag_b,
    output logic              neg_res,
    output logic              neg_rem,
    input  logic [2*XLEN-1:0] work,
    input  logic              fix_neg_res,
    input  logic              fix_neg_rem,
    input  logic              div_zero,
    output logic [XLEN-1:0]   res_hi,
    output logic [XLEN-1:0]   res_lo
);

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;

    // Magnitudes and sign flags; unsigned ops pass straight through.
    always_comb begin
        mag_a   = (is_signed && in_a[XLEN-1]) ? (~in_a + 1'b1) : in_a;
        mag_b   = (is_signed && in_b[XLEN-1]) ? (~in_b + 1'b1) : in_b;
        neg_res = is_signed && (in_a[XLEN-1] ^ in_b[XLEN-1]);
        neg_rem = is_signed && in_a[XLEN-1];
    end

    // Sign correction of the finished result. The 0x80000000 / -1 case
    // falls out naturally: magnitude quotient 0x80000000, no negation.
    always_comb begin
        prod = fix_neg_res ? (~work + 1'b1) : work;
        quot = fix_neg_res ? (~work[XLEN-1:0] + 1'b1) : work[XLEN-1:0];
        rem  = fix_neg_rem ? (~work[2*XLEN-1:XLEN] + 1'b1) : work[2*XLEN-1:XLEN];
        if (is_div) begin
            // With a zero divisor the remainder half has accumulated |a|, so
            // the remainder sign fix restores a itself; only lo is forced.
            res_hi = rem;
            res_lo = div_zero ? DIV0_LO : quot;
        end else begin
            res_hi = prod[2*XLEN-1:XLEN];
            res_lo = prod[XLEN-1:0];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit with HI/LO result registers.
// One operation takes 34 cycles: PREP (1), RUN (32 steps), FIX (1).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    state_t            state_reg;
    op_t               op_reg;
    logic [2*XLEN-1:0] work_reg;   // mul: {partial hi, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]   opnd_reg;   // multiplicand or divisor magnitude
    logic [5:0]        cnt_reg;
    logic              neg_res_reg;
    logic              neg_rem_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [XLEN-1:0]   hi_reg;
    logic [XLEN-1:0]   lo_reg;

    logic              is_signed;
    logic              is_div;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              neg_res;
    logic              neg_rem;
    logic [XLEN-1:0]   res_hi;
    logic [XLEN-1:0]   res_lo;
    logic [2*XLEN-1:0] work_next;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_rem;
    logic [XLEN:0]     div_diff;

    assign is_signed = op_is_signed(op_reg);
    assign is_div    = (op_reg == OP_DIV) || (op_reg == OP_DIVU);

    // In PREP the raw dividend/multiplicand sits in work_reg[XLEN-1:0].
    muldiv_signfix #(.XLEN(XLEN)) u_signfix (
        .is_signed   (is_signed),
        .is_div      (is_div),
        .in_a        (work_reg[XLEN-1:0]),
        .in_b        (opnd_reg),
        .mag_a       (mag_a),
        .mag_b       (mag_b),
        .neg_res     (neg_res),
        .neg_rem     (neg_rem),
        .work        (work_reg),
        .fix_neg_res (neg_res_reg),
        .fix_neg_rem (neg_rem_reg),
        .div_zero    (opnd_reg == '0),
        .res_hi      (res_hi),
        .res_lo      (res_lo)
    );

    // One RUN step: shift-add multiply or restoring shift-subtract divide.
    always_comb begin
        mul_sum  = {1'b0, work_reg[2*XLEN-1:XLEN]} + {1'b0, opnd_reg};
        div_rem  = work_reg[2*XLEN-1:XLEN-1];
        div_diff = div_rem - {1'b0, opnd_reg};
        work_next = work_reg;
        if (is_div) begin
            if (div_rem >= {1'b0, opnd_reg}) begin
                work_next = {div_diff[XLEN-1:0], work_reg[XLEN-2:0], 1'b1};
            end else begin
                work_next = {work_reg[2*XLEN-2:0], 1'b0};
            end
        end else begin
            if (work_reg[0]) begin
                work_next = {mul_sum, work_reg[XLEN-1:1]};
            end else begin
                work_next = {1'b0, work_reg[2*XLEN-1:1]};
            end
        end
    end

    // Control FSM, datapath registers and HI/LO commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            op_reg      <= OP_MULT;
            work_reg    <= '0;
            opnd_reg    <= '0;
            cnt_reg     <= '0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        // Start wins over a same-cycle mthi/mtlo.
                        op_reg    <= op_t'(op);
                        work_reg  <= {{XLEN{1'b0}}, a};
                        opnd_reg  <= b;
                        busy_reg  <= 1'b1;
                        state_reg <= PREP;
                    end else begin
                        if (mthi) hi_reg <= wdata;
                        if (mtlo) lo_reg <= wdata;
                    end
                end
                PREP: begin
                    work_reg    <= {{XLEN{1'b0}}, mag_a};
                    opnd_reg    <= mag_b;
                    neg_res_reg <= neg_res;
                    neg_rem_reg <= neg_rem;
                    cnt_reg     <= '0;
                    state_reg   <= RUN;
                end
                RUN: begin
                    work_reg <= work_next;
                    cnt_reg  <= cnt_reg + 6'd1;
                    if (cnt_reg == 6'(ITER - 1)) state_reg <= FIX;
                end
                FIX: begin
                    hi_reg    <= res_hi;
                    lo_reg    <= res_lo;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random
// operations against an arithmetic reference, and hand-written sequences
// for busy-time inputs, mthi/mtlo and mid-operation reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference results from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx;
        longint          sy;
        longint unsigned ux;
        longint unsigned uy;
        logic [63:0]     q;
        logic [63:0]     r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            2'd0: return 64'(sx * sy);
            2'd1: return 64'(ux * uy);
            2'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = 64'(sx / sy);
                r = 64'(sx % sy);
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = 64'(ux / uy);
                r = 64'(ux % uy);
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Called at a falling edge; start is sampled at the next rising edge (E0).
    // Operands are scrambled right after capture. Returns the latency in
    // edges from E0 to done, busy cycles seen, and done one cycle later.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] rh, output logic [31:0] rl,
                          output int lat, output int bcnt, output logic dw);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
        lat   = 0;
        bcnt  = 0;
        while (lat < 45 && !done) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        rh = hi;
        rl = lo;
        @(negedge clk);
        dw = done;
    endtask

    task automatic check_op(input string nm, input logic [1:0] o, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
        logic [31:0] rh;
        logic [31:0] rl;
        int          lat;
        int          bcnt;
        logic        dw;
        run_op(o, x, y, rh, rl, lat, bcnt, dw);
        $display("op %s: op=%0d a=%08h b=%08h -> hi=%08h lo=%08h lat=%0d", nm, o, x, y, rh, rl, lat);
        chk({nm, " latency"}, 64'(lat), 64'd34);
        chk({nm, " busy_cycles"}, 64'(bcnt), 64'd34);
        chk({nm, " done_width"}, {63'd0, dw}, 64'd0);
        chk({nm, " hi"}, {32'd0, rh}, {32'd0, eh});
        chk({nm, " lo"}, {32'd0, rl}, {32'd0, el});
    endtask

    vec_t vecs[9];

    initial begin
        logic [63:0] m;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  ro;
        int          n;
        int          dcnt;

        vecs[0] = '{"multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{"mult_neg3x5", 2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2] = '{"div_neg7by2", 2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{"div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4] = '{"divu_by0", 2'd3, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
        vecs[5] = '{"div_neg_by0", 2'd2, 32'hFFFF_FF9C, 32'h0000_0000, 32'hFFFF_FF9C, 32'hFFFF_FFFF};
        vecs[6] = '{"div_7byneg2", 2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[7] = '{"mult_minsq", 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8] = '{"divu_by16", 2'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};

        rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset hi", {32'd0, hi}, 64'd0);
        chk("reset lo", {32'd0, lo}, 64'd0);

        // Release and request in the same cycle: first edge after release accepts.
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
        end

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            m = model(ro, ra, rb);
            check_op("random", ro, ra, rb, m[63:32], m[31:0]);
        end

        // Both HI and LO written in the same idle cycle.
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hAAAA_0000;
        @(posedge clk);
        @(negedge clk);
        mtlo = 1'b1; mthi = 1'b0; wdata = 32'h0000_BBBB;
        @(posedge clk);
        @(negedge clk);
        mtlo = 1'b0;
        $display("mthi+mtlo: hi=%08h lo=%08h", hi, lo);
        chk("mthi_mtlo hi", {32'd0, hi}, 64'hAAAA_0000);
        chk("mthi_mtlo lo", {32'd0, lo}, 64'h0000_BBBB);

        // Start while busy plus mthi while busy, both ignored.
        start = 1'b1; op = 2'd1; a = 32'h0001_0003; b = 32'h0002_0005;
        @(posedge clk);                    // E0
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);         // E1..E4
        @(negedge clk);
        start = 1'b1; op = 2'd2; a = 32'h1111_1111; b = 32'h0000_0003;
        mthi = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clk);                    // E5
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        chk("busy_ign busy", {63'd0, busy}, 64'd1);
        chk("busy_ign hi_hold", {32'd0, hi}, 64'hAAAA_0000);
        chk("busy_ign lo_hold", {32'd0, lo}, 64'h0000_BBBB);
        n = 5;
        while (n < 45 && !done) begin
            @(negedge clk);
            n++;
        end
        m = model(2'd1, 32'h0001_0003, 32'h0002_0005);
        $display("busy_ign: hi=%08h lo=%08h done_edge=%0d", hi, lo, n);
        chk("busy_ign done_edge", 64'(n), 64'd34);
        chk("busy_ign hi", {32'd0, hi}, {32'd0, m[63:32]});
        chk("busy_ign lo", {32'd0, lo}, {32'd0, m[31:0]});
        mtlo = 1'b1; wdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        mtlo = 1'b0;
        $display("mtlo idle: hi=%08h lo=%08h", hi, lo);
        chk("mtlo lo", {32'd0, lo}, 64'h1234_5678);
        chk("mtlo hi_hold", {32'd0, hi}, {32'd0, m[63:32]});

        // Reset in the middle of a divide.
        start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd7;
        @(posedge clk);                    // E0
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);        // E1..E10
        #2 rst = 1'b1;
        #1;
        $display("mid reset: busy=%0d done=%0d hi=%08h lo=%08h", busy, done, hi, lo);
        chk("midrst busy", {63'd0, busy}, 64'd0);
        chk("midrst done", {63'd0, done}, 64'd0);
        chk("midrst hi", {32'd0, hi}, 64'd0);
        chk("midrst lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        $display("post reset: done pulses in 40 cycles=%0d", dcnt);
        chk("midrst no_done", 64'(dcnt), 64'd0);
        m = model(2'd2, 32'd1000, 32'd7);
        check_op("after_reset", 2'd2, 32'd1000, 32'd7, m[63:32], m[31:0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
